// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: source side (op, x, y) and
// consumer side (z plus status flags), each with its own valid/ready pair.
interface alu_pipe_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] z;
  logic         zf;
  logic         nf;
  logic         cf;
  logic         vf;

  modport master (
    output in_valid, op, x, y, out_ready,
    input  in_ready, out_valid, z, zf, nf, cf, vf
  );

  modport slave (
    input  in_valid, op, x, y, out_ready,
    output in_ready, out_valid, z, zf, nf, cf, vf
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined N-bit ALU with flags and accumulator. S1 holds the
// accepted operation, S2 is the output register; either side may stall.
module alu_pipe #(
  parameter int N  = 4,
  parameter int SW = $clog2(N) + 1
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOT = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_XOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SHL = 3'b110,
    OP_ACC = 3'b111
  } op_e;

  logic         s1_valid_q, s1_valid_d;
  op_e          op_q, op_d;
  logic [N-1:0] x_q, x_d;
  logic [N-1:0] y_q, y_d;

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] z_q, z_d;
  logic         zf_q, zf_d;
  logic         nf_q, nf_d;
  logic         cf_q, cf_d;
  logic         vf_q, vf_d;
  logic [N-1:0] acc_q, acc_d;

  logic         accept;
  logic         s2_load;
  logic         in_ready;

  logic [N:0]   add_res;
  logic [N:0]   sub_res;
  logic [N:0]   acc_res;
  logic [N:0]   shl_res;
  logic [N-1:0] alu_z;
  logic         alu_cf;
  logic         alu_vf;

  function automatic logic add_ovf(input logic a, input logic b, input logic r);
    return (a == b) && (r != a);
  endfunction

  function automatic logic sub_ovf(input logic a, input logic b, input logic r);
    return (a != b) && (r != a);
  endfunction

  // S1 may refill in the same cycle it drains, so in_ready looks only at
  // downstream state and never at in_valid.
  assign s2_load  = s1_valid_q & (~out_valid_q | bus.out_ready);
  assign in_ready = ~s1_valid_q | ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    s1_valid_d = accept | (s1_valid_q & ~s2_load);
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    if (accept) begin
      op_d = op_e'(bus.op);
      x_d  = bus.x;
      y_d  = bus.y;
    end
  end

  // Shifting a zero-extended x leaves the last bit shifted out in bit N;
  // s = 0 and s > N both fall out naturally as cf = 0.
  always_comb begin
    add_res = {1'b0, x_q} + {1'b0, y_q};
    sub_res = {1'b0, x_q} - {1'b0, y_q};
    acc_res = {1'b0, acc_q} + {1'b0, x_q};
    shl_res = {1'b0, x_q} << y_q[SW-1:0];
    alu_z   = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    unique case (op_q)
      OP_NOT: alu_z = ~x_q;
      OP_AND: alu_z = x_q & y_q;
      OP_OR:  alu_z = x_q | y_q;
      OP_XOR: alu_z = x_q ^ y_q;
      OP_ADD: begin
        alu_z  = add_res[N-1:0];
        alu_cf = add_res[N];
        alu_vf = add_ovf(x_q[N-1], y_q[N-1], add_res[N-1]);
      end
      OP_SUB: begin
        alu_z  = sub_res[N-1:0];
        alu_cf = sub_res[N];
        alu_vf = sub_ovf(x_q[N-1], y_q[N-1], sub_res[N-1]);
      end
      OP_SHL: begin
        alu_z  = shl_res[N-1:0];
        alu_cf = shl_res[N];
      end
      OP_ACC: begin
        alu_z  = acc_res[N-1:0];
        alu_cf = acc_res[N];
        alu_vf = add_ovf(acc_q[N-1], x_q[N-1], acc_res[N-1]);
      end
      default: alu_z = '0;
    endcase
  end

  always_comb begin
    out_valid_d = s2_load | (out_valid_q & ~bus.out_ready);
    z_d         = z_q;
    zf_d        = zf_q;
    nf_d        = nf_q;
    cf_d        = cf_q;
    vf_d        = vf_q;
    acc_d       = acc_q;
    if (s2_load) begin
      z_d  = alu_z;
      zf_d = (alu_z == '0);
      nf_d = alu_z[N-1];
      cf_d = alu_cf;
      vf_d = alu_vf;
      if (op_q == OP_ACC) begin
        acc_d = alu_z;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      op_q        <= OP_NOT;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      zf_q        <= 1'b0;
      nf_q        <= 1'b0;
      cf_q        <= 1'b0;
      vf_q        <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      op_q        <= op_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      zf_q        <= zf_d;
      nf_q        <= nf_d;
      cf_q        <= cf_d;
      vf_q        <= vf_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.zf        = zf_q;
  assign bus.nf        = nf_q;
  assign bus.cf        = cf_q;
  assign bus.vf        = vf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed vector bench for alu_pipe (N=4): streamed table plus hand-written
// backpressure and mid-flight reset sequences.
module tb_alu_pipe;
  localparam int N  = 4;
  localparam int NV = 23;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.N(N)) bus ();
  alu_pipe #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [2:0] op;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
    logic [3:0] f;   // {zf, nf, cf, vf}
  } vec_t;

  vec_t vt [NV];
  int   drv_cyc [NV];
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   obs_idx = 0;
  bit   mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y,
                              input logic [3:0] z, input logic [3:0] f);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.z = z; v.f = f;
    return v;
  endfunction

  function automatic logic [3:0] flags();
    return {bus.zf, bus.nf, bus.cf, bus.vf};
  endfunction

  // Result scoreboard for the streamed table: in order, one per handshake.
  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (obs_idx < NV) begin
        chk($sformatf("v%0d z", obs_idx), 32'(bus.z), 32'(vt[obs_idx].z));
        chk($sformatf("v%0d flags", obs_idx), 32'(flags()), 32'(vt[obs_idx].f));
        chk($sformatf("v%0d latency", obs_idx), 32'(cyc), 32'(drv_cyc[obs_idx] + 2));
      end else begin
        chk("extra result", 32'(obs_idx), 32'(NV - 1));
      end
      obs_idx++;
    end
  end

  task automatic drive(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.x        = x;
    bus.y        = y;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.x         = '0;
    bus.y         = '0;
    bus.out_ready = 1'b1;

    vt[0]  = mk(3'b000, 4'b1111, 4'b0000, 4'b0000, 4'b1000);
    vt[1]  = mk(3'b000, 4'b0000, 4'b0000, 4'b1111, 4'b0100);
    vt[2]  = mk(3'b000, 4'b1010, 4'b0000, 4'b0101, 4'b0000);
    vt[3]  = mk(3'b100, 4'b0111, 4'b0001, 4'b1000, 4'b0101);
    vt[4]  = mk(3'b100, 4'b1111, 4'b0001, 4'b0000, 4'b1010);
    vt[5]  = mk(3'b100, 4'b0100, 4'b0100, 4'b1000, 4'b0101);
    vt[6]  = mk(3'b101, 4'b0011, 4'b0101, 4'b1110, 4'b0110);
    vt[7]  = mk(3'b101, 4'b1000, 4'b0001, 4'b0111, 4'b0001);
    vt[8]  = mk(3'b101, 4'b0101, 4'b0101, 4'b0000, 4'b1000);
    vt[9]  = mk(3'b110, 4'b1001, 4'b0001, 4'b0010, 4'b0010);
    vt[10] = mk(3'b110, 4'b1001, 4'b0110, 4'b0000, 4'b1000);
    vt[11] = mk(3'b110, 4'b1001, 4'b0000, 4'b1001, 4'b0100);
    vt[12] = mk(3'b110, 4'b1001, 4'b0100, 4'b0000, 4'b1010);
    vt[13] = mk(3'b110, 4'b0011, 4'b0011, 4'b1000, 4'b0110);
    vt[14] = mk(3'b110, 4'b0001, 4'b1100, 4'b0000, 4'b1010);
    vt[15] = mk(3'b110, 4'b1111, 4'b0101, 4'b0000, 4'b1000);
    vt[16] = mk(3'b001, 4'b1100, 4'b1010, 4'b1000, 4'b0100);
    vt[17] = mk(3'b010, 4'b0001, 4'b0010, 4'b0011, 4'b0000);
    vt[18] = mk(3'b011, 4'b1111, 4'b0101, 4'b1010, 4'b0100);
    vt[19] = mk(3'b111, 4'b0101, 4'b1111, 4'b0101, 4'b0000);
    vt[20] = mk(3'b111, 4'b0101, 4'b0000, 4'b1010, 4'b0101);
    vt[21] = mk(3'b111, 4'b0111, 4'b0000, 4'b0001, 4'b0010);
    vt[22] = mk(3'b111, 4'b0000, 4'b0000, 4'b0001, 4'b0000);

    // Reset state
    #2;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset z", 32'(bus.z), 32'd0);
    chk("reset flags", 32'(flags()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready after reset", 32'(bus.in_ready), 32'd1);

    // Streamed table, out_ready held high: one result per cycle
    mon_en = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].op, vt[i].x, vt[i].y);
      drv_cyc[i] = cyc;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int w = 0; w < 20 && obs_idx < NV; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("table result count", 32'(obs_idx), 32'(NV));
    mon_en = 1'b0;

    // Backpressure: two accepted, third held off until the consumer drains
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(3'b001, 4'b1100, 4'b1010);
    #1;
    chk("bp in_ready empty", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    drive(3'b010, 4'b0001, 4'b0010);
    #1;
    chk("bp in_ready s1 only", 32'(bus.in_ready), 32'd1);
    chk("bp out_valid early", 32'(bus.out_valid), 32'd0);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      drive(3'b011, 4'b1111, 4'b0101);
      #1;
      chk($sformatf("bp stall in_ready %0d", h), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp stall out_valid %0d", h), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp stall z %0d", h), 32'(bus.z), 32'b1000);
      chk($sformatf("bp stall flags %0d", h), 32'(flags()), 32'b0100);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp out0 z", 32'(bus.z), 32'b1000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("bp out1 valid", 32'(bus.out_valid), 32'd1);
    chk("bp out1 z", 32'(bus.z), 32'b0011);
    @(negedge clk);
    #1;
    chk("bp out2 valid", 32'(bus.out_valid), 32'd1);
    chk("bp out2 z", 32'(bus.z), 32'b1010);
    @(negedge clk);
    #1;
    chk("bp drained", 32'(bus.out_valid), 32'd0);

    // Mid-flight reset with two operations held in the pipe
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(3'b000, 4'b0000, 4'b0000);
    @(negedge clk);
    drive(3'b111, 4'b0010, 4'b0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("rst pre out_valid", 32'(bus.out_valid), 32'd1);
    chk("rst pre z", 32'(bus.z), 32'b1111);
    #1;
    rst_n = 1'b0;
    #3;
    chk("rst async out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst async z", 32'(bus.z), 32'd0);
    chk("rst async flags", 32'(flags()), 32'd0);
    #4;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst no stale %0d", s), 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    drive(3'b111, 4'b0011, 4'b0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int w = 0; w < 10 && !bus.out_valid; w++) @(negedge clk);
    chk("rst acc out_valid", 32'(bus.out_valid), 32'd1);
    chk("rst acc z", 32'(bus.z), 32'b0011);
    chk("rst acc flags", 32'(flags()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined N-bit ALU. It is the successor to the team's 4-bit combinational NOT unit and extends it to eight operations, status flags, an internal accumulator, and valid/ready flow control. The block sits between an operand source and a result consumer, and either side may stall. It is built with two register stages and supports full throughput.

Parameters:
N, 4, operand/result width in bits (N >= 2)
SW, $clog2(N)+1, width of the shift-amount field taken from y[SW-1:0]

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  op/x/y are valid this cycle
in_ready  out  1  block accepts an operation this cycle
op  in  3  operation select (see Behaviour)
x  in  N  operand A
y  in  N  operand B / shift amount
out_valid  out  1  z and flags are valid
out_ready  in  1  consumer accepts the result this cycle
z  out  N  result
zf  out  1  zero flag (z == 0)
nf  out  1  negative flag (z[N-1])
cf  out  1  carry / borrow / shifted-out bit
vf  out  1  signed overflow

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid, out_valid and the accumulator are 0.
  - z, zf, nf, cf and vf are 0.
  - in_ready is 1 once reset is released.
- Stage 1 (S1): registers op, x and y on accept (in_valid & in_ready).
- Stage 2 (S2): computes from S1 and registers z and the flags. S2 is the output register.
- Advance and stall rules:
  - S2 loads when s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | !out_valid | out_ready (combinational, no combinational path from in_valid).
  - When out_valid=1 and out_ready=0, z and all flags hold stable. At most 2 operations are in flight.
  - Simultaneous accept at S1, move S1->S2 and consumer take: all three occur in the same cycle, giving 1 result per cycle.
- Latency: an operation accepted at edge k has out_valid=1 after edge k+1 when there is no stall.
- Operations (all arithmetic is modulo 2^N):
  - 000 NOT: z = ~x
  - 001 AND: z = x & y
  - 010 OR: z = x | y
  - 011 XOR: z = x ^ y
  - 100 ADD: z = x + y; cf = carry out; vf = signed overflow
  - 101 SUB: z = x - y; cf = 1 iff x < y unsigned (borrow); vf = signed overflow
  - 110 SHL: s = y[SW-1:0]
    - s = 0: z = x, cf = 0.
    - 1 <= s <= N: z = x << s, cf = x[N-s].
    - s > N: z = 0, cf = 0.
  - 111 ACC: z = acc + x, cf = carry out, vf = signed overflow. acc is loaded with z in the same edge that S2 loads.
- cf and vf are 0 for NOT, AND and OR. XOR also forces cf and vf to 0. vf is 0 for SHL.
- zf and nf are always derived from the registered z.
- The accumulator is updated only by ACC. It is never cleared except by reset, and it wraps silently on overflow.
- Reset mid-operation: all in-flight operations are discarded, no result is emitted, and acc returns to 0.
- Inputs arriving while in_ready=0 are ignored. The source must hold them stable until accepted.

Test Plan:
1. N=4, out_ready=1; NOT x=1111, then x=0000, x=1010 back-to-back -> z=0000 (zf=1), 1111 (nf=1), 0101. out_valid is high for 3 consecutive cycles starting 2 edges after the first accept.
2. ADD x=0111 y=0001 -> z=1000, nf=1, vf=1, cf=0. ADD x=1111 y=0001 -> z=0000, zf=1, cf=1, vf=0.
3. SUB x=0011 y=0101 -> z=1110, cf=1, nf=1, vf=0. SHL x=1001 y=0001 -> z=0010, cf=1. SHL x=1001 y=0110 -> z=0000, zf=1, cf=0.
4. Backpressure: out_ready=0, offer 3 ops (AND 1100&1010, OR 0001|0010, XOR 1111^0101).
   - First two are accepted, then in_ready=0 and z stays at 1000.
   - Release out_ready -> z=1000, then 0011, then 1010 on consecutive cycles.
   - No operation is lost or duplicated.
5. ACC x=0101, 0101, 0111 -> z=0101, 1010 (vf=1, nf=1), 0001 (cf=1). A following ACC x=0000 -> z=0001 (acc persists).
6. With 2 ops in flight, pulse rst_n low for a non-clock-aligned interval -> out_valid, z, flags and acc are 0 immediately. No stale result appears after release, and an ACC x=0011 then yields z=0011.
